paddle_motion_ctrl: RTL and testbench

Sequences the paddle datapath of the breakout game. Turns the player's left/right button levels into rate-limited, clamped paddle X positions, stepping at a fixed tick rate. Honours the game-wide pause. Its `x_pos` output feeds the renderer and ball-collision logic in place of a raw initial position.

---
 rtl/paddle_pkg.sv | 30 +++
 rtl/tick_divider.sv | 29 ++
 rtl/paddle_motion_ctrl.sv | 129 ++++++++++++
 tb/tb_paddle_motion_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/paddle_pkg.sv
// Shared types and constants for the breakout paddle datapath.
// Default geometry, FSM state encoding and the speed-doubling helper.
package paddle_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE_L = 2'd1,
        MOVE_R = 2'd2
    } paddle_state_t;

    localparam int X_W             = 10;
    localparam int SCREEN_W_DEF    = 640;
    localparam int PADDLE_W_DEF    = 64;
    localparam int X_INIT_DEF      = 288;
    localparam int STEP_DIV_DEF    = 250000;
    localparam int ACCEL_TICKS_DEF = 32;
    localparam int STEP_MAX        = 4;
    localparam int STEP_W          = 3;

    // 1 -> 2 -> 4, then holds at STEP_MAX.
    function automatic logic [STEP_W-1:0] step_double(input logic [STEP_W-1:0] s);
        logic [STEP_W-1:0] r;
        if (s >= STEP_W'(STEP_MAX / 2))
            r = STEP_W'(STEP_MAX);
        else
            r = {s[STEP_W-2:0], 1'b0};
        return r;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running timebase: one-cycle tick every DIV enabled clocks.
// Count freezes while en is low, so no tick is lost or added across a hold.
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (en)
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end

    assign tick = en & w_last;

endmodule

// File: rtl/paddle_motion_ctrl.sv
// Paddle X sequencer: button levels -> clamped X, one move per tick, frozen by pause.
// x_pos/moving update on the tick edge; optional speed ramp under PADDLE_ACCEL_EN.
module paddle_motion_ctrl
    import paddle_pkg::*;
#(
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int PADDLE_W    = PADDLE_W_DEF,
    parameter int X_INIT      = X_INIT_DEF,
    parameter int STEP_DIV    = STEP_DIV_DEF,
    parameter int ACCEL_TICKS = ACCEL_TICKS_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pause,
    input  logic           move_left,
    input  logic           move_right,
    output logic [X_W-1:0] x_pos,
    output logic           moving,
    output logic           at_left,
    output logic           at_right
);

    localparam logic [X_W-1:0] RLIM   = X_W'(SCREEN_W - PADDLE_W);
    localparam logic [X_W-1:0] X_RST  = X_W'(X_INIT);

    logic          w_run;
    logic          w_tick;
    paddle_state_t r_state;
    paddle_state_t w_state_nxt;
    logic [X_W-1:0]    r_x;
    logic [X_W-1:0]    w_x_nxt;
    logic [X_W:0]      w_sum;
    logic [STEP_W-1:0] w_step;

    assign w_run = ~pause;

    tick_divider #(
        .DIV (STEP_DIV)
    ) u_tick_divider (
        .clk   (clk),
        .reset (reset),
        .en    (w_run),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_x     <= X_RST;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
        end
    end

    // Direction and move are both taken from the buttons seen at this tick.
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_sum       = {1'b0, r_x} + (X_W + 1)'(w_step);
        if (w_tick) begin
            case ({move_left, move_right})
                2'b10:   w_state_nxt = MOVE_L;
                2'b01:   w_state_nxt = MOVE_R;
                default: w_state_nxt = IDLE;
            endcase
            case (w_state_nxt)
                MOVE_L:  w_x_nxt = (r_x < X_W'(w_step)) ? '0 : r_x - X_W'(w_step);
                MOVE_R:  w_x_nxt = (w_sum > {1'b0, RLIM}) ? RLIM : w_sum[X_W-1:0];
                default: w_x_nxt = r_x;
            endcase
        end
    end

`ifdef PADDLE_ACCEL_EN
    localparam int HOLD_W = $clog2(ACCEL_TICKS + 1);

    logic [STEP_W-1:0] r_step;
    logic [STEP_W-1:0] w_step_nxt;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [HOLD_W-1:0] w_hold_cur;
    logic [HOLD_W-1:0] w_hold_inc;
    logic              w_restart;

    // The tick that enters a move state counts as its first held tick.
    always_comb begin
        w_restart  = (w_state_nxt != r_state) || (w_state_nxt == IDLE);
        w_step     = w_restart ? STEP_W'(1) : r_step;
        w_hold_cur = w_restart ? '0 : r_hold;
        w_hold_inc = w_hold_cur + HOLD_W'(1);
        w_step_nxt = r_step;
        w_hold_nxt = r_hold;
        if (w_tick) begin
            if (w_state_nxt == IDLE) begin
                w_step_nxt = STEP_W'(1);
                w_hold_nxt = '0;
            end else if (w_hold_inc == HOLD_W'(ACCEL_TICKS)) begin
                w_step_nxt = step_double(w_step);
                w_hold_nxt = '0;
            end else begin
                w_step_nxt = w_step;
                w_hold_nxt = w_hold_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_step <= STEP_W'(1);
            r_hold <= '0;
        end else begin
            r_step <= w_step_nxt;
            r_hold <= w_hold_nxt;
        end
    end
`else
    logic [31:0] w_unused_accel;

    assign w_unused_accel = 32'(ACCEL_TICKS);
    assign w_step         = STEP_W'(1);
`endif

    assign x_pos    = r_x;
    assign moving   = (r_state != IDLE);
    assign at_left  = (r_x == '0);
    assign at_right = (r_x == RLIM);

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Scoreboard bench: per-clock reference model pushes expected outputs, monitor pops and compares.
module tb_paddle_motion_ctrl;

    localparam int SCREEN_W = 640;
    localparam int PADDLE_W = 64;
    localparam int XI       = 288;
    localparam int STEP_DIV = 4;
    localparam int ACCEL    = 2;
    localparam int RLIM     = SCREEN_W - PADDLE_W;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pause = 1'b0;
    logic       move_left = 1'b0;
    logic       move_right = 1'b0;
    logic [9:0] x_pos;
    logic       moving;
    logic       at_left;
    logic       at_right;

    paddle_motion_ctrl #(
        .SCREEN_W    (SCREEN_W),
        .PADDLE_W    (PADDLE_W),
        .X_INIT      (XI),
        .STEP_DIV    (STEP_DIV),
        .ACCEL_TICKS (ACCEL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pause      (pause),
        .move_left  (move_left),
        .move_right (move_right),
        .x_pos      (x_pos),
        .moving     (moving),
        .at_left    (at_left),
        .at_right   (at_right)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        bit mv;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: position, direction (-1/0/+1), phase within tick period, ticks held.
    int m_x     = XI;
    int m_dir   = 0;
    int m_phase = 0;
    int m_run   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_x = XI; m_dir = 0; m_phase = 0; m_run = 0;
            end else if (!pause) begin
                if (m_phase == STEP_DIV - 1) begin
                    int nd;
                    int st;
                    int lvl;
                    nd  = (move_left && !move_right) ? -1 : ((move_right && !move_left) ? 1 : 0);
                    if (nd != m_dir) m_run = 0;
                    lvl = m_run / ACCEL;
                    if (lvl > 2) lvl = 2;
                    st  = 1;
`ifdef PADDLE_ACCEL_EN
                    st  = 1 << lvl;
`endif
                    m_x = m_x + nd * st;
                    if (m_x < 0) m_x = 0;
                    if (m_x > RLIM) m_x = RLIM;
                    m_dir = nd;
                    m_run++;
                end
                m_phase = (m_phase + 1) % STEP_DIV;
            end
            q.push_back('{m_x, m_dir != 0});
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("x_pos", 32'(x_pos), e.x);
                check("moving", 32'(moving), 32'(e.mv));
                check("at_left", 32'(at_left), 32'(e.x == 0));
                check("at_right", 32'(at_right), 32'(e.x == RLIM));
            end
        end
    end

    task automatic drive(input bit l, input bit r, input bit p, input bit rst, input int n);
        move_left  = l;
        move_right = r;
        pause      = p;
        reset      = rst;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 1, 3);
        check("reset_x", 32'(x_pos), XI);
        check("reset_moving", 32'(moving), 0);

        // First move lands exactly STEP_DIV clocks after reset release.
        drive(0, 1, 0, 0, STEP_DIV - 1);
        check("pre_tick_x", 32'(x_pos), XI);
        drive(0, 1, 0, 0, 1);
        check("first_tick_x", 32'(x_pos), XI + 1);
        drive(0, 1, 0, 0, 4 * STEP_DIV);
`ifdef PADDLE_ACCEL_EN
        check("right5_x", 32'(x_pos), XI + 10);
        drive(0, 1, 0, 0, STEP_DIV);
        check("right6_accel_x", 32'(x_pos), 302);
        drive(1, 0, 0, 0, STEP_DIV);
        check("reverse_step1_x", 32'(x_pos), 301);
`else
        check("right5_x", 32'(x_pos), XI + 5);
`endif
        check("right_moving", 32'(moving), 1);

        drive(1, 0, 0, 0, 300 * STEP_DIV);
        check("left_floor_x", 32'(x_pos), 0);
        check("left_floor_at_left", 32'(at_left), 1);

        drive(0, 1, 0, 0, 600 * STEP_DIV);
        check("right_pin_x", 32'(x_pos), RLIM);
        check("right_pin_at_right", 32'(at_right), 1);
        drive(0, 1, 0, 0, STEP_DIV);
        check("right_pin_again_x", 32'(x_pos), RLIM);
        check("right_pin_moving", 32'(moving), 1);

        drive(1, 1, 0, 0, 10 * STEP_DIV);
        check("both_moving", 32'(moving), 0);
        check("both_x", 32'(x_pos), RLIM);

        drive(1, 0, 0, 0, STEP_DIV);
        check("leave_right_x", 32'(x_pos), RLIM - 1);

        // Pause mid-count with a button held.
        drive(0, 1, 0, 0, 2);
        drive(0, 1, 1, 0, 20);
        check("pause_x", 32'(x_pos), m_x);
        drive(0, 1, 0, 0, 3 * STEP_DIV);

        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0,
                  $urandom_range(1, 30));
        end

        drive(0, 0, 0, 0, 3);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
